// File: rtl/apb_cmd_master.sv
// APB3 requester: turns one register-access command at a time into an APB transfer,
// bounds each access with a wait timeout and keeps saturating error counters.
module apb_cmd_master #(
  parameter int ADDR_BITS = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] cmd_addr_in,
  input  logic [31:0]          cmd_wdata_in,
  input  logic                 cmd_write_in,
  input  logic                 cmd_vld_in,
  output logic                 cmd_rdy_out,
  output logic [31:0]          rsp_data_out,
  output logic [1:0]           rsp_err_out,
  output logic                 rsp_write_out,
  output logic                 rsp_vld_out,
  input  logic                 rsp_rdy_in,
  output logic                 apb_psel_out,
  output logic                 apb_penable_out,
  output logic                 apb_pwrite_out,
  output logic [ADDR_BITS-1:0] apb_paddr_out,
  output logic [31:0]          apb_pwdata_out,
  input  logic [31:0]          apb_prdata_in,
  input  logic                 apb_pready_in,
  input  logic                 apb_pslverr_in,
  output logic [7:0]           tout_cnt_out,
  output logic [7:0]           serr_cnt_out
);

  // Counter only has to reach TIMEOUT-1; with TIMEOUT=0 it free-runs unused.
  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] TO_LAST = WCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state;
  logic [WCNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      cmd_rdy_out     <= 1'b0;
      rsp_data_out    <= '0;
      rsp_err_out     <= 2'b00;
      rsp_write_out   <= 1'b0;
      rsp_vld_out     <= 1'b0;
      apb_psel_out    <= 1'b0;
      apb_penable_out <= 1'b0;
      apb_pwrite_out  <= 1'b0;
      apb_paddr_out   <= '0;
      apb_pwdata_out  <= '0;
      tout_cnt_out    <= 8'd0;
      serr_cnt_out    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          cmd_rdy_out <= 1'b1;
          if (cmd_vld_in && cmd_rdy_out) begin
            cmd_rdy_out    <= 1'b0;
            apb_psel_out   <= 1'b1;
            apb_paddr_out  <= {cmd_addr_in[ADDR_BITS-1:2], 2'b00};
            apb_pwrite_out <= cmd_write_in;
            apb_pwdata_out <= cmd_write_in ? cmd_wdata_in : 32'd0;
            wait_cnt       <= '0;
            state          <= SETUP;
          end
        end
        SETUP: begin
          apb_penable_out <= 1'b1;
          state           <= ACCESS;
        end
        ACCESS: begin
          // pready wins over a timeout landing in the same cycle
          if (apb_pready_in) begin
            apb_psel_out    <= 1'b0;
            apb_penable_out <= 1'b0;
            rsp_data_out    <= apb_pwrite_out ? 32'd0 : apb_prdata_in;
            rsp_err_out     <= apb_pslverr_in ? 2'b01 : 2'b00;
            rsp_write_out   <= apb_pwrite_out;
            rsp_vld_out     <= 1'b1;
            if (apb_pslverr_in && serr_cnt_out != 8'hff)
              serr_cnt_out <= serr_cnt_out + 8'd1;
            state <= RESP;
          end else if (TO_EN && wait_cnt == TO_LAST) begin
            apb_psel_out    <= 1'b0;
            apb_penable_out <= 1'b0;
            rsp_data_out    <= 32'd0;
            rsp_err_out     <= 2'b10;
            rsp_write_out   <= apb_pwrite_out;
            rsp_vld_out     <= 1'b1;
            if (tout_cnt_out != 8'hff)
              tout_cnt_out <= tout_cnt_out + 8'd1;
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_rdy_in) begin
            rsp_vld_out <= 1'b0;
            cmd_rdy_out <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
